// File: rtl/register_scoreboard_pkg.sv
// Shared parameters and drain FSM encodings for the register scoreboard.
// Imported by the scoreboard top and its hazard-check sub-module.
package register_scoreboard_pkg;

    localparam int unsigned REGISTER_INDEX_WIDTH = 5;
    localparam int unsigned NUM_REGISTERS        = 32;
    localparam int unsigned PEND_CNT_WIDTH       = 3;

    localparam logic [1:0] SB_RUN     = 2'd0;
    localparam logic [1:0] SB_DRAIN   = 2'd1;
    localparam logic [1:0] SB_DRAINED = 2'd2;

    // Load count once this cycle's memory writeback has been retired; never wraps below zero.
    function automatic logic [PEND_CNT_WIDTH-1:0] loads_after_wb(
        input logic [PEND_CNT_WIDTH-1:0] cnt,
        input logic                      mem_wb
    );
        if (mem_wb && (cnt != '0)) begin
            return cnt - 1'b1;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/register_scoreboard_hazard_check.sv
// Combinational RAW/WAW/structural hazard evaluation for the instruction in decode.
// Same-cycle writebacks are forwarded, so they mask the corresponding busy bits.
module scoreboard_hazard_check #(
    parameter int unsigned REGISTER_INDEX_WIDTH = register_scoreboard_pkg::REGISTER_INDEX_WIDTH,
    parameter int unsigned NUM_REGISTERS        = register_scoreboard_pkg::NUM_REGISTERS,
    parameter int unsigned MAX_PENDING_LOADS    = 2
) (
    input  logic [NUM_REGISTERS-1:0]        busy_i,
    input  logic [2:0]                      pending_loads_i,
    input  logic [REGISTER_INDEX_WIDTH-1:0] src_1_i,
    input  logic [REGISTER_INDEX_WIDTH-1:0] src_2_i,
    input  logic [REGISTER_INDEX_WIDTH-1:0] dst_i,
    input  logic                            writes_dst_i,
    input  logic                            is_load_i,
    input  logic                            alu_wb_valid_i,
    input  logic [REGISTER_INDEX_WIDTH-1:0] alu_wb_idx_i,
    input  logic                            mem_wb_valid_i,
    input  logic [REGISTER_INDEX_WIDTH-1:0] mem_wb_idx_i,
    output logic                            raw_o,
    output logic                            waw_o,
    output logic                            struct_o,
    output logic                            hazard_o,
    output logic [2:0]                      loads_after_wb_o
);
    import register_scoreboard_pkg::*;

    localparam logic [2:0] MaxLoads = 3'(MAX_PENDING_LOADS);

    logic [NUM_REGISTERS-1:0] eff_busy;

    always_comb begin
        eff_busy = busy_i;
        if (alu_wb_valid_i) begin
            eff_busy[alu_wb_idx_i] = 1'b0;
        end
        if (mem_wb_valid_i) begin
            eff_busy[mem_wb_idx_i] = 1'b0;
        end
        eff_busy[0] = 1'b0;
    end

    always_comb begin
        raw_o            = eff_busy[src_1_i] | eff_busy[src_2_i];
        waw_o            = writes_dst_i & eff_busy[dst_i];
        loads_after_wb_o = loads_after_wb(pending_loads_i, mem_wb_valid_i);
        struct_o         = is_load_i & (loads_after_wb_o == MaxLoads);
        hazard_o         = raw_o | waw_o | struct_o;
    end

endmodule

// File: rtl/register_scoreboard.sv
// Register scoreboard and issue controller for decode: tracks outstanding writes,
// throttles loads, gates issue and sequences a drain (fence) until the pipeline is quiet.
module register_scoreboard #(
    parameter int unsigned REGISTER_INDEX_WIDTH = register_scoreboard_pkg::REGISTER_INDEX_WIDTH,
    parameter int unsigned NUM_REGISTERS        = register_scoreboard_pkg::NUM_REGISTERS,
    parameter int unsigned MAX_PENDING_LOADS    = 2,
    parameter int unsigned STALL_COUNT_WIDTH    = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            issue_valid,
    input  logic [REGISTER_INDEX_WIDTH-1:0] issue_idx_src_1,
    input  logic [REGISTER_INDEX_WIDTH-1:0] issue_idx_src_2,
    input  logic [REGISTER_INDEX_WIDTH-1:0] issue_idx_dst,
    input  logic                            issue_writes_dst,
    input  logic                            issue_is_load,
    input  logic                            alu_wb_valid,
    input  logic [REGISTER_INDEX_WIDTH-1:0] alu_wb_idx,
    input  logic                            mem_wb_valid,
    input  logic [REGISTER_INDEX_WIDTH-1:0] mem_wb_idx,
    input  logic                            drain_req,
    output logic                            issue_fire,
    output logic                            stall,
    output logic                            drain_done,
    output logic [NUM_REGISTERS-1:0]        busy_mask,
    output logic [STALL_COUNT_WIDTH-1:0]    stall_cycles
);
    import register_scoreboard_pkg::*;

    logic [NUM_REGISTERS-1:0]     busy_q, busy_d;
    logic [2:0]                   pend_q, pend_d;
    logic [1:0]                   state_q, state_d;
    logic                         drain_done_q, drain_done_d;
    logic [STALL_COUNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    logic       raw_hz, waw_hz, struct_hz, hazard;
    logic [2:0] loads_after_wb;
    logic       quiet;

    scoreboard_hazard_check #(
        .REGISTER_INDEX_WIDTH (REGISTER_INDEX_WIDTH),
        .NUM_REGISTERS        (NUM_REGISTERS),
        .MAX_PENDING_LOADS    (MAX_PENDING_LOADS)
    ) u_hazard_check (
        .busy_i           (busy_q),
        .pending_loads_i  (pend_q),
        .src_1_i          (issue_idx_src_1),
        .src_2_i          (issue_idx_src_2),
        .dst_i            (issue_idx_dst),
        .writes_dst_i     (issue_writes_dst),
        .is_load_i        (issue_is_load),
        .alu_wb_valid_i   (alu_wb_valid),
        .alu_wb_idx_i     (alu_wb_idx),
        .mem_wb_valid_i   (mem_wb_valid),
        .mem_wb_idx_i     (mem_wb_idx),
        .raw_o            (raw_hz),
        .waw_o            (waw_hz),
        .struct_o         (struct_hz),
        .hazard_o         (hazard),
        .loads_after_wb_o (loads_after_wb)
    );

    // drain_req blocks issue combinationally, before the FSM has left RUN.
    assign issue_fire = issue_valid & (state_q == SB_RUN) & ~drain_req & ~hazard;
    assign stall      = issue_valid & ~issue_fire;

    always_comb begin
        busy_d = busy_q;
        if (alu_wb_valid) begin
            busy_d[alu_wb_idx] = 1'b0;
        end
        if (mem_wb_valid) begin
            busy_d[mem_wb_idx] = 1'b0;
        end
        // Set after clear so a same-cycle reissue keeps the register busy.
        if (issue_fire && issue_writes_dst) begin
            busy_d[issue_idx_dst] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        pend_d = loads_after_wb;
        if (issue_fire && issue_is_load) begin
            pend_d = loads_after_wb + 3'd1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    assign quiet = (busy_d == '0) && (pend_d == 3'd0);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SB_RUN: begin
                if (drain_req) begin
                    state_d = SB_DRAIN;
                end
            end
            SB_DRAIN: begin
                if (!drain_req) begin
                    state_d = SB_RUN;
                end else if (quiet) begin
                    state_d = SB_DRAINED;
                end
            end
            SB_DRAINED: begin
                if (!drain_req) begin
                    state_d = SB_RUN;
                end
            end
            default: state_d = SB_RUN;
        endcase
        drain_done_d = (state_d == SB_DRAINED);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_q       <= '0;
            pend_q       <= 3'd0;
            state_q      <= SB_RUN;
            drain_done_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            busy_q       <= busy_d;
            pend_q       <= pend_d;
            state_q      <= state_d;
            drain_done_q <= drain_done_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign drain_done   = drain_done_q;
    assign busy_mask    = busy_q;
    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_register_scoreboard.sv
// Directed plus randomized bench for register_scoreboard, checked against an
// abstract model (bit-per-register array, integer load count, drain phase).
module tb_register_scoreboard;

    localparam int MaxLoads = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_idx_src_1, issue_idx_src_2, issue_idx_dst;
    logic        issue_writes_dst, issue_is_load;
    logic        alu_wb_valid, mem_wb_valid;
    logic [4:0]  alu_wb_idx, mem_wb_idx;
    logic        drain_req;
    logic        issue_fire, stall, drain_done;
    logic [31:0] busy_mask, stall_cycles;

    int errors = 0;
    int checks = 0;
    logic last_fire;

    // Model state
    bit          m_busy[32];
    int          m_pend;
    int          m_phase;  // 0 running, 1 draining, 2 drained
    longint      m_stalls;

    register_scoreboard #(
        .REGISTER_INDEX_WIDTH (5),
        .NUM_REGISTERS        (32),
        .MAX_PENDING_LOADS    (MaxLoads),
        .STALL_COUNT_WIDTH    (32)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .issue_valid      (issue_valid),
        .issue_idx_src_1  (issue_idx_src_1),
        .issue_idx_src_2  (issue_idx_src_2),
        .issue_idx_dst    (issue_idx_dst),
        .issue_writes_dst (issue_writes_dst),
        .issue_is_load    (issue_is_load),
        .alu_wb_valid     (alu_wb_valid),
        .alu_wb_idx       (alu_wb_idx),
        .mem_wb_valid     (mem_wb_valid),
        .mem_wb_idx       (mem_wb_idx),
        .drain_req        (drain_req),
        .issue_fire       (issue_fire),
        .stall            (stall),
        .drain_done       (drain_done),
        .busy_mask        (busy_mask),
        .stall_cycles     (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit hz_busy(input int r);
        if (r == 0 || !m_busy[r]) return 1'b0;
        if (alu_wb_valid && int'(alu_wb_idx) == r) return 1'b0;
        if (mem_wb_valid && int'(mem_wb_idx) == r) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int loads_left();
        return (mem_wb_valid && m_pend > 0) ? m_pend - 1 : m_pend;
    endfunction

    function automatic bit model_fire();
        if (!issue_valid || m_phase != 0 || drain_req) return 1'b0;
        if (hz_busy(int'(issue_idx_src_1)) || hz_busy(int'(issue_idx_src_2))) return 1'b0;
        if (issue_writes_dst && hz_busy(int'(issue_idx_dst))) return 1'b0;
        if (issue_is_load && loads_left() == MaxLoads) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_mask();
        logic [31:0] m;
        for (int r = 0; r < 32; r++) m[r] = m_busy[r];
        return m;
    endfunction

    task automatic model_update(input bit fire);
        bit quiet;
        if (!reset) begin
            for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
            m_pend = 0; m_phase = 0; m_stalls = 0;
            return;
        end
        m_pend = loads_left() + ((fire && issue_is_load) ? 1 : 0);
        if (alu_wb_valid) m_busy[alu_wb_idx] = 1'b0;
        if (mem_wb_valid) m_busy[mem_wb_idx] = 1'b0;
        if (fire && issue_writes_dst && issue_idx_dst != 0) m_busy[issue_idx_dst] = 1'b1;
        if (issue_valid && !fire && m_stalls < 64'hFFFF_FFFF) m_stalls++;
        quiet = (model_mask() == 32'd0) && (m_pend == 0);
        case (m_phase)
            0: if (drain_req) m_phase = 1;
            1: if (!drain_req) m_phase = 0; else if (quiet) m_phase = 2;
            default: if (!drain_req) m_phase = 0;
        endcase
    endtask

    // Inputs are driven just after a falling edge; outputs sampled 1 time unit later.
    task automatic run_cycle();
        bit ef;
        #1;
        ef = model_fire();
        chk("issue_fire", {63'd0, issue_fire}, {63'd0, ef});
        chk("stall", {63'd0, stall}, {63'd0, issue_valid & ~ef});
        chk("busy_mask", {32'd0, busy_mask}, {32'd0, model_mask()});
        chk("drain_done", {63'd0, drain_done}, {63'd0, m_phase == 2});
        chk("stall_cycles", {32'd0, stall_cycles}, m_stalls);
        last_fire = issue_fire;
        @(posedge clk);
        model_update(ef);
        @(negedge clk);
    endtask

    task automatic clear_in();
        issue_valid = 0; issue_idx_src_1 = 0; issue_idx_src_2 = 0; issue_idx_dst = 0;
        issue_writes_dst = 0; issue_is_load = 0;
        alu_wb_valid = 0; alu_wb_idx = 0; mem_wb_valid = 0; mem_wb_idx = 0;
    endtask

    task automatic instr(input int s1, input int s2, input int d, input bit ld);
        issue_valid = 1; issue_idx_src_1 = 5'(s1); issue_idx_src_2 = 5'(s2);
        issue_idx_dst = 5'(d); issue_writes_dst = 1; issue_is_load = ld;
    endtask

    initial begin
        clear_in();
        drain_req = 0;
        reset = 0;
        m_pend = 0; m_phase = 0; m_stalls = 0;
        for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1;

        // Idle after reset
        run_cycle();
        chk("idle_mask", {32'd0, busy_mask}, 64'd0);

        // First issue on an empty board
        instr(3, 4, 5, 0);
        run_cycle();
        chk("first_fire", {63'd0, last_fire}, 64'd1);
        chk("mask_0x20", {32'd0, busy_mask}, 64'h20);

        // Dependent on r5: three stalls, then released by ALU writeback
        instr(5, 0, 6, 0);
        repeat (3) run_cycle();
        chk("stall_count_3", {32'd0, stall_cycles}, 64'd3);
        alu_wb_valid = 1; alu_wb_idx = 5;
        run_cycle();
        chk("wb_release", {63'd0, last_fire}, 64'd1);
        clear_in(); alu_wb_valid = 1; alu_wb_idx = 6;
        run_cycle();

        // Same-cycle set and clear on r7: set wins
        clear_in(); instr(0, 0, 7, 0); alu_wb_valid = 1; alu_wb_idx = 7;
        run_cycle();
        chk("set_wins", {32'd0, busy_mask}, 64'h80);
        clear_in(); alu_wb_valid = 1; alu_wb_idx = 0; mem_wb_valid = 1; mem_wb_idx = 3;
        run_cycle();
        chk("noop_wb", {32'd0, busy_mask}, 64'h80);
        clear_in(); instr(0, 0, 7, 0);
        run_cycle();
        chk("waw_stall", {63'd0, last_fire}, 64'd0);
        clear_in(); alu_wb_valid = 1; alu_wb_idx = 7;
        run_cycle();

        // Load throttle
        clear_in(); instr(0, 0, 10, 1); run_cycle();
        instr(0, 0, 11, 1); run_cycle();
        instr(0, 0, 12, 1); run_cycle();
        chk("load_throttle", {63'd0, last_fire}, 64'd0);
        mem_wb_valid = 1; mem_wb_idx = 10;
        run_cycle();
        chk("load_release", {63'd0, last_fire}, 64'd1);
        clear_in(); mem_wb_valid = 1; mem_wb_idx = 11; run_cycle();
        mem_wb_idx = 12; run_cycle();
        clear_in(); run_cycle();
        chk("loads_clear", {32'd0, busy_mask}, 64'd0);

        // Drain with r5 and r9 busy
        instr(0, 0, 5, 0); run_cycle();
        instr(0, 0, 9, 0); run_cycle();
        clear_in(); instr(1, 0, 2, 0); drain_req = 1;
        run_cycle();
        chk("drain_blocks", {63'd0, last_fire}, 64'd0);
        alu_wb_valid = 1; alu_wb_idx = 5; run_cycle();
        chk("not_yet_drained", {63'd0, drain_done}, 64'd0);
        alu_wb_idx = 9; run_cycle();
        chk("drained", {63'd0, drain_done}, 64'd1);
        clear_in(); drain_req = 0; run_cycle();
        chk("back_to_run", {63'd0, drain_done}, 64'd0);
        instr(0, 0, 5, 0); run_cycle();
        clear_in(); drain_req = 1; run_cycle();
        reset = 0; run_cycle();
        reset = 1; drain_req = 0;
        chk("reset_mask", {32'd0, busy_mask}, 64'd0);
        chk("reset_stalls", {32'd0, stall_cycles}, 64'd0);
        run_cycle();

        // Randomized traffic over a small register window to provoke hazards
        for (int i = 0; i < 600; i++) begin
            issue_valid      = ($urandom_range(0, 3) != 0);
            issue_idx_src_1  = 5'($urandom_range(0, 7));
            issue_idx_src_2  = 5'($urandom_range(0, 7));
            issue_idx_dst    = 5'($urandom_range(0, 7));
            issue_writes_dst = ($urandom_range(0, 4) != 0);
            issue_is_load    = ($urandom_range(0, 2) == 0);
            alu_wb_valid     = ($urandom_range(0, 2) == 0);
            alu_wb_idx       = 5'($urandom_range(0, 7));
            mem_wb_valid     = ($urandom_range(0, 3) == 0);
            mem_wb_idx       = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) drain_req = ~drain_req;
            reset            = ($urandom_range(0, 99) != 0);
            run_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/register_scoreboard.md
# register_scoreboard

Register scoreboard and issue controller for the decode stage. It tracks which architectural registers have an outstanding write from the ALU or the memory unit, and decides each cycle whether the instruction in decode may issue or must stall. It also throttles outstanding loads and sequences a drain (fence) request until the pipeline is quiet. It sits between decode and the execution/memory stages and replaces per-cycle index comparisons with tracked per-register state.

## Interface
- `REGISTER_INDEX_WIDTH`, 5: register index width.
- `NUM_REGISTERS`, 32: architectural registers; register 0 is hardwired zero.
- `MAX_PENDING_LOADS`, 2: maximum loads in flight (1..7).
- `STALL_COUNT_WIDTH`, 32: width of the stall-cycle counter.

Ports:
- `clk`, in, 1: clock; all state changes on the rising edge.
- `reset`, in, 1: reset, synchronous, active-low.
- `issue_valid`, in, 1: decode holds a valid instruction.
- `issue_idx_src_1`, in, REGISTER_INDEX_WIDTH: first source index.
- `issue_idx_src_2`, in, REGISTER_INDEX_WIDTH: second source index.
- `issue_idx_dst`, in, REGISTER_INDEX_WIDTH: destination index.
- `issue_writes_dst`, in, 1: instruction writes `issue_idx_dst`.
- `issue_is_load`, in, 1: instruction is a load; its destination is written back by memory.
- `alu_wb_valid`, in, 1: ALU writes back this cycle.
- `alu_wb_idx`, in, REGISTER_INDEX_WIDTH: ALU writeback index.
- `mem_wb_valid`, in, 1: memory load writes back this cycle.
- `mem_wb_idx`, in, REGISTER_INDEX_WIDTH: memory writeback index.
- `drain_req`, in, 1: level request to quiesce (fence).
- `issue_fire`, out, 1: instruction issues this cycle.
- `stall`, out, 1: `issue_valid & ~issue_fire`.
- `drain_done`, out, 1: registered; pipeline is quiet while the drain is held.
- `busy_mask`, out, NUM_REGISTERS: current busy bits (debug).
- `stall_cycles`, out, STALL_COUNT_WIDTH: saturating count of stalled cycles.

## Operation
- State:
  - `busy[NUM_REGISTERS]`, with bit 0 constant 0.
  - `pending_loads`, a counter of 3 bits.
  - Drain FSM with states `RUN`, `DRAIN` and `DRAINED`.
- Effective busy for hazard checks: `busy[r] & ~(alu_wb_valid & alu_wb_idx==r) & ~(mem_wb_valid & mem_wb_idx==r)`. A same-cycle writeback is forwarded and is not a hazard.
- `issue_fire = issue_valid & state==RUN` and none of the following hazards is present:
  - RAW: effective busy on src_1 or src_2 (index 0 is never a hazard).
  - WAW: `issue_writes_dst` and effective busy on dst (dst≠0).
  - Structural: `issue_is_load` and `pending_loads == MAX_PENDING_LOADS` after this cycle's `mem_wb_valid` decrement.
- Busy bit update each edge: clear bits on writeback, then set bit dst on `issue_fire & issue_writes_dst & dst≠0`. If a set and a clear hit the same register in the same cycle, set wins.
- `pending_loads` update: +1 on load fire, −1 on `mem_wb_valid`. Both in the same cycle means no change. A `mem_wb_valid` with count 0 is ignored; there is no wrap.
- Writeback to a register that is not busy, or to index 0: no effect.
- `stall_cycles` increments when `stall` is 1 and saturates at all-ones.
- Drain FSM:
  - RUN → DRAIN on `drain_req`. Issue is blocked from the cycle `drain_req` is first seen.
  - DRAIN → DRAINED when `busy` is all-zero and `pending_loads==0`, evaluated on post-update values.
  - DRAINED → RUN when `drain_req` is low.
  - DRAIN → RUN if `drain_req` drops before the pipeline is quiet.
  - `drain_done` = 1 only in DRAINED.

## Timing
- Reset (`reset`==0 at an edge):
  - `busy` = 0, `pending_loads` = 0, state RUN, `stall_cycles` = 0.
  - `drain_done` = 0, `busy_mask` = 0.
  - Reset takes priority over every event in the same cycle, including mid-drain.
- `issue_fire` and `stall` are combinational from registered state and the current inputs, with no added latency. Decode must hold its inputs while `stall`=1.
- Busy bit visibility:
  - A bit set by a fire at edge N is visible to the instruction in decode during cycle N+1. Back-to-back dependent instructions therefore stall until writeback.
  - A writeback in cycle N releases a dependent instruction in that same cycle N.
- `drain_done` rises at the earliest one edge after quiet.

## Structure
- Shared parameters include file:
  - `REGISTER_INDEX_WIDTH`, `NUM_REGISTERS`.
  - Drain FSM state encodings `SB_RUN`=2'd0, `SB_DRAIN`=2'd1, `SB_DRAINED`=2'd2.
  - A display macro in the style of the existing debug macros.
- One sub-module, `scoreboard_hazard_check`: purely combinational RAW/WAW/structural evaluation over `busy` and the writeback buses. The top module holds all sequential state.

## Test plan
- Reset then idle: all outputs 0.
- `issue_valid` with src 3/4 and dst 5 on an empty board → `issue_fire`=1; next cycle `busy_mask`=0x20.
- Dependent stall:
  - Issue dst 5, then src_1=5 → `stall`=1 for 3 cycles, and `stall_cycles`=3.
  - `alu_wb_valid` idx 5 in the 4th cycle → fire that same cycle.
- Same-cycle set/clear and WAW:
  - Fire dst 7 while `alu_wb_idx`=7 → bit 7 stays set.
  - A writeback to 0 or to a non-busy register changes nothing.
  - WAW on dst 7 stalls.
- Load throttle: two load fires (different dst) → third load stalls. When `mem_wb_valid` arrives, the third fires in that cycle and `pending_loads` stays 2.
- Drain:
  - `drain_req` with bits 5 and 9 busy → issue blocked; `drain_done`=1 one edge after the last writeback.
  - Dropping `drain_req` → RUN.
  - Asserting `reset`=0 during DRAIN → all cleared.
